ws2812_rz_decoder: RTL and testbench

//  Receive side of the WS2812 single-wire RZ link: samples a DIN line, classifies each

---
 rtl/ws2812_rz_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_ws2812_rz_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rz_decoder.sv
// ws2812_rz_decoder
//   Receive side of a WS2812 single-wire RZ link.
//   - Synchronizes DIN and measures each high pulse.
//   - Classifies each pulse as a 0 or 1 bit.
//   - Assembles 24-bit GRB pixels, MSB (G7) first.
//   - A long low gap marks the frame boundary.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : asynchronous RZ serial input
//   pix_data    : last decoded pixel {G,R,B}; held between strobes
//   pix_valid   : 1-cycle strobe, pix_data/pix_idx updated
//   pix_idx     : index of pix_data within the current frame
//   frame_done  : 1-cycle strobe at a reset gap ending a non-empty frame
//   err         : 1-cycle strobe on a decode error
//   dout        : cascaded output (pixel-chain emulation only)
// Configuration
//   WS2812_FWD_EN defined   : only the first pixel of each frame is decoded.
//                             The rest of the frame is forwarded to dout
//                             (din -> dout delay of 3 cycles).
//   WS2812_FWD_EN undefined : bus monitor; every pixel is decoded, dout = 0.
module ws2812_rz_decoder #(
  parameter int T_MIN_HIGH = 5,
  parameter int T_THRESH   = 30,
  parameter int T_MAX_HIGH = 100,
  parameter int T_RESET    = 2500,
  parameter int IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [23:0]      pix_data,
  output logic             pix_valid,
  output logic [IDX_W-1:0] pix_idx,
  output logic             frame_done,
  output logic             err,
  output logic             dout
);

`ifdef WS2812_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  localparam int CNT_MAX = (T_RESET > T_MAX_HIGH + 1) ? T_RESET : T_MAX_HIGH + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] C_MAX   = CW'(CNT_MAX);
  localparam logic [CW-1:0] C_RST1  = CW'(T_RESET - 1);
  localparam logic [CW-1:0] C_MIN   = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0] C_THR   = CW'(T_THRESH);
  localparam logic [CW-1:0] C_HMAX  = CW'(T_MAX_HIGH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [1:0] {S_SYNC, S_LOW, S_HIGH} state_t;

  state_t           state_q, state_d;
  logic             din_meta_q, din_s_q;
  logic [CW-1:0]    low_cnt_q, low_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [23:0]      shreg_q, shreg_d, pix_data_q, pix_data_d;
  logic [IDX_W-1:0] idx_q, idx_d, pix_idx_q, pix_idx_d;
  logic             has_pix_q, has_pix_d, fwd_q, fwd_d;
  logic             pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
  logic             err_q, err_d, dout_q, dout_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == C_MAX) ? v : v + C_ONE;
  endfunction

  // State register (plus all datapath flops)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SYNC;
      din_meta_q   <= 1'b0;
      din_s_q      <= 1'b0;
      low_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      idx_q        <= '0;
      has_pix_q    <= 1'b0;
      fwd_q        <= 1'b0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_meta_q   <= din;
      din_s_q      <= din_meta_q;
      low_cnt_q    <= low_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      has_pix_q    <= has_pix_d;
      fwd_q        <= fwd_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC: if (!din_s_q && low_cnt_q >= C_RST1) state_d = S_LOW;
      S_LOW:  if (din_s_q) state_d = S_HIGH;
      S_HIGH: begin
        if (din_s_q && hi_cnt_q >= C_HMAX) state_d = S_SYNC;
        else if (!din_s_q)                 state_d = S_LOW;
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Datapath and output strobes
  always_comb begin
    low_cnt_d    = low_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    idx_d        = idx_q;
    has_pix_d    = has_pix_q;
    fwd_d        = fwd_q;
    pix_data_d   = pix_data_q;
    pix_idx_d    = pix_idx_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    // A full pixel is published on the cycle after its 24th bit lands.
    if (bit_cnt_q == 5'd24) begin
      pix_data_d  = shreg_q;
      pix_idx_d   = idx_q;
      pix_valid_d = 1'b1;
      bit_cnt_d   = '0;
      has_pix_d   = 1'b1;
      if (FWD_EN) fwd_d = 1'b1;
      else        idx_d = idx_q + 1'b1;
    end

    case (state_q)
      S_SYNC: begin
        low_cnt_d = din_s_q ? '0 : sat_inc(low_cnt_q);
        fwd_d     = 1'b0;
        // Gap found: start a fresh frame silently; anything before the
        // error that sent us here is abandoned.
        if (state_d == S_LOW) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          has_pix_d = 1'b0;
        end
      end
      S_LOW: begin
        if (din_s_q) begin
          hi_cnt_d = C_ONE;  // low count is kept in case this is a glitch
        end else begin
          low_cnt_d = sat_inc(low_cnt_q);
          // Strobe only on the exact crossing so a long gap fires once.
          if (low_cnt_q == C_RST1) begin
            frame_done_d = has_pix_q;
            err_d        = (bit_cnt_q != 5'd0);
            bit_cnt_d    = '0;
            idx_d        = '0;
            has_pix_d    = 1'b0;
            fwd_d        = 1'b0;
          end
        end
      end
      S_HIGH: begin
        if (din_s_q) begin
          hi_cnt_d = sat_inc(hi_cnt_q);
          if (hi_cnt_q >= C_HMAX) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
            low_cnt_d = '0;
            fwd_d     = 1'b0;
          end
        end else if (hi_cnt_q < C_MIN) begin
          low_cnt_d = sat_inc(low_cnt_q);  // glitch: resume the low run
        end else begin
          low_cnt_d = C_ONE;
          if (!fwd_q) begin
            shreg_d   = {shreg_q[22:0], (hi_cnt_q >= C_THR)};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      default: ;
    endcase

    dout_d = FWD_EN && fwd_q && (state_q != S_SYNC) && din_s_q;
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign pix_idx    = pix_idx_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_ws2812_rz_decoder.sv
// Scoreboard bench for ws2812_rz_decoder: stimulus pushes expected events,
// a negedge monitor pops them when the DUT strobes.
module tb_ws2812_rz_decoder;
  localparam int EV_PIX = 0, EV_ERR = 1, EV_FD = 2;

  typedef struct {
    int          kind;
    logic [23:0] data;
    logic [7:0]  idx;
  } ev_t;

  logic        clk = 1'b0, rst_n = 1'b0, din = 1'b0;
  logic [23:0] pix_data;
  logic [7:0]  pix_idx;
  logic        pix_valid, frame_done, err, dout;

  ev_t  exp_q[$];
  int   checks = 0, failures = 0;
  int   dout_bad = 0;
  logic zero_win = 1'b0, fwd_win = 1'b0;
  logic [2:0] din_h = 3'b000;

  ws2812_rz_decoder dut (
    .clk(clk), .rst_n(rst_n), .din(din), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_idx(pix_idx), .frame_done(frame_done),
    .err(err), .dout(dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) din_h = {din_h[1:0], din};

  task automatic push(input int k, input logic [23:0] d, input logic [7:0] ix);
    ev_t e;
    e.kind = k; e.data = d; e.idx = ix;
    exp_q.push_back(e);
  endtask

  task automatic chk_ev(input int k, input logic [23:0] d, input logic [7:0] ix);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d data=%06h idx=%0d required=none", k, d, ix);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_PIX && (e.data !== d || e.idx !== ix))) begin
        failures++;
        $display("FAIL event got kind=%0d data=%06h idx=%0d required kind=%0d data=%06h idx=%0d",
                 k, d, ix, e.kind, e.data, e.idx);
      end
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid)  chk_ev(EV_PIX, pix_data, pix_idx);
      if (err)        chk_ev(EV_ERR, 24'h0, 8'h0);
      if (frame_done) chk_ev(EV_FD, 24'h0, 8'h0);
      if (zero_win && dout !== 1'b0) dout_bad++;
      if (fwd_win && dout !== din_h[2]) dout_bad++;
    end
  end

  task automatic lo(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic hi(input int n);
    din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One bit, period 63: T0H=20, T1H=40. Optional 3-cycle glitch in the low phase.
  task automatic send_bit(input logic b, input logic glitch);
    hi(b ? 40 : 20);
    if (glitch) begin
      lo(10); hi(3); lo((b ? 23 : 43) - 13);
    end else begin
      lo(b ? 23 : 43);
    end
  endtask

  task automatic send_bits(input logic [23:0] v, input int n, input int gl_bit);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], (i == gl_bit));
  endtask

  task automatic send_px(input logic [23:0] v);
    send_bits(v, 24, -1);
  endtask

  task automatic chk_idle(input string tag);
    chk_val({tag, "_pix_data"}, {8'h0, pix_data}, 32'h0);
    chk_val({tag, "_pix_valid"}, {31'h0, pix_valid}, 32'h0);
    chk_val({tag, "_pix_idx"}, {24'h0, pix_idx}, 32'h0);
    chk_val({tag, "_frame_done"}, {31'h0, frame_done}, 32'h0);
    chk_val({tag, "_err"}, {31'h0, err}, 32'h0);
    chk_val({tag, "_dout"}, {31'h0, dout}, 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
`ifndef WS2812_FWD_EN
    zero_win = 1'b1;
`endif

    // 1: single pixel, then gap
    lo(2600);
    push(EV_PIX, 24'hFF0080, 8'd0);
    send_px(24'hFF0080);
    push(EV_FD, 24'h0, 8'h0);
    lo(2600);

    // 2: three pixels back to back
    push(EV_PIX, 24'h123456, 8'd0);
`ifndef WS2812_FWD_EN
    push(EV_PIX, 24'hABCDEF, 8'd1);
    push(EV_PIX, 24'h000001, 8'd2);
`endif
    send_px(24'h123456);
    send_px(24'hABCDEF);
    send_px(24'h000001);
    push(EV_FD, 24'h0, 8'h0);
    lo(2600);

    // 3: glitch inside a low phase is ignored
    push(EV_PIX, 24'h5A5A5A, 8'd0);
    send_bits(24'h5A5A5A, 24, 13);
    push(EV_FD, 24'h0, 8'h0);
    lo(2600);

    // 4: partial pixel then gap -> err only; next pixel starts at idx 0
    send_bits(24'h000ABC, 10, -1);
    push(EV_ERR, 24'h0, 8'h0);
    lo(2600);
    push(EV_PIX, 24'h00FF00, 8'd0);
    send_px(24'h00FF00);
    push(EV_FD, 24'h0, 8'h0);
    lo(2600);

    // 5: over-long high -> err, SYNC; bits ignored until a gap
    push(EV_PIX, 24'h111111, 8'd0);
    send_px(24'h111111);
    send_bits(24'h00001F, 5, -1);
    push(EV_ERR, 24'h0, 8'h0);
    hi(150);
    lo(40);
    send_px(24'hFFFFFF);
    lo(2600);
    push(EV_PIX, 24'h222222, 8'd0);
    send_px(24'h222222);
    push(EV_FD, 24'h0, 8'h0);
    lo(2600);

    // mid-frame reset aborts without strobes and clears outputs
    send_bits(24'h000FFF, 12, -1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("midreset");
    rst_n = 1'b1;
    lo(2600);
    push(EV_PIX, 24'h00000F, 8'd0);
    send_px(24'h00000F);
    push(EV_FD, 24'h0, 8'h0);
    lo(2600);

`ifdef WS2812_FWD_EN
    // 6: chain emulation, second pixel replayed on dout
    push(EV_PIX, 24'h010203, 8'd0);
    zero_win = 1'b1;
    send_px(24'h010203);
    zero_win = 1'b0;
    fwd_win = 1'b1;
    send_px(24'h0A0B0C);
    lo(5);
    fwd_win = 1'b0;
    push(EV_FD, 24'h0, 8'h0);
    lo(2600);
`endif

    lo(50);
    chk_val("pix_data_hold", {8'h0, pix_data}, 32'h00000F
`ifdef WS2812_FWD_EN
            + 32'h010203 - 32'h00000F
`endif
           );
    chk_val("dout_bad_cycles", dout_bad, 32'h0);
    chk_val("scoreboard_left", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
